// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
//
// I2S receiver: turns an external BCLK/LRCLK/SDATA stream (DATA_W-bit words
// carried MSB-first in each channel slot) into parallel two's-complement
// samples in the clk domain. One left/right pair per frame is presented on
// sample_left / sample_right, with a mono mix on audio_out and a one-cycle
// sample_valid strobe.
//
// Parameters
//   DATA_W    sample width in bits
//   MONO_SEL  audio_out source: 0 = left, 1 = right, 2 = floor((L+R)/2)
//   TIMEOUT   clk cycles without a BCLK rising edge before lock is dropped
//
// Ports
//   clk           system clock (must be at least 4x BCLK)
//   rst_n         asynchronous active-low reset
//   i2s_bclk      serial bit clock, asynchronous to clk
//   i2s_lrclk     word select, 0 = left, 1 = right
//   i2s_sdata     serial data, sampled on BCLK rising edges
//   sample_left   last complete left word
//   sample_right  last complete right word
//   audio_out     mono sample selected by MONO_SEL
//   sample_valid  one-cycle pulse when the three sample outputs update
//   locked        high while the receiver is in RUN
//   frame_err     one-cycle pulse when a slot closes with fewer than DATA_W bits
//   fsm_state     debug view of the receiver state (0 = SEARCH, 1 = RUN)
//
// Handshake: sample_valid is a pure strobe with no back-pressure; the sample
// outputs are stable from one sample_valid pulse until the next one.
// ---------------------------------------------------------------------------
module i2s_rx #(
  parameter int DATA_W   = 24,
  parameter int MONO_SEL = 0,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic [DATA_W-1:0] audio_out,
  output logic              sample_valid,
  output logic              locked,
  output logic              frame_err,
  output logic              fsm_state
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DATA_W);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  typedef enum logic {
    SEARCH = 1'b0,
    RUN    = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronisers. All three pins use the same depth so that a data or
  // word-select change made on the BCLK falling edge stays aligned with the
  // BCLK edges once inside the clk domain.
  // -------------------------------------------------------------------------
  logic bclk_s1, bclk_s2, bclk_d;
  logic lr_s1, lr_s2;
  logic sdata_s1, sdata_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_s1  <= 1'b0;
      bclk_s2  <= 1'b0;
      bclk_d   <= 1'b0;
      lr_s1    <= 1'b0;
      lr_s2    <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      bclk_s1  <= i2s_bclk;
      bclk_s2  <= bclk_s1;
      bclk_d   <= bclk_s2;
      lr_s1    <= i2s_lrclk;
      lr_s2    <= lr_s1;
      sdata_s1 <= i2s_sdata;
      sdata_s2 <= sdata_s1;
    end
  end

  // -------------------------------------------------------------------------
  // Receiver state
  // -------------------------------------------------------------------------
  state_t              state;
  logic                lr_prev;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   left_hold;
  logic [IDLE_W-1:0]   idle_cnt;

  logic                rise;
  logic                is_switch;
  logic                short_word;
  logic [CNT_W-1:0]    shamt;
  logic [DATA_W-1:0]   word;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   avg_word;
  logic [DATA_W-1:0]   mono_word;

  assign rise      = bclk_s2 & ~bclk_d;
  // The switch edge is the I2S one-bit delay slot: it closes the previous
  // word and its data bit is thrown away.
  assign is_switch = rise & (lr_s2 != lr_prev);
  assign fsm_state = state;

  always_comb begin
    // A short slot leaves its bits at the bottom of shreg; shifting by the
    // missing bit count left-justifies the word and zero-fills the tail.
    shamt      = FULL_CNT - bit_cnt;
    word       = shreg << shamt;
    short_word = (bit_cnt != FULL_CNT);
    // Sign-extend by one bit so the sum cannot overflow; dropping the LSB of
    // the sum is an arithmetic shift right, i.e. floor((L+R)/2).
    sum        = {left_hold[DATA_W-1], left_hold} + {word[DATA_W-1], word};
    avg_word   = sum[DATA_W:1];
  end

  always_comb begin
    mono_word = left_hold;
    if (MONO_SEL == 1) begin
      mono_word = word;
    end else if (MONO_SEL == 2) begin
      mono_word = avg_word;
    end
  end

  // -------------------------------------------------------------------------
  // Capture / framing state machine with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEARCH;
      lr_prev      <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      idle_cnt     <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      audio_out    <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      // Idle counter saturates so that a long stall in SEARCH stays harmless.
      if (rise) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (rise) begin
        lr_prev <= lr_s2;
      end

      if ((state == RUN) && (idle_cnt == IDLE_MAX)) begin
        // BCLK has gone away: drop any half-built frame, keep the last
        // published samples on the outputs.
        state     <= SEARCH;
        locked    <= 1'b0;
        bit_cnt   <= '0;
        shreg     <= '0;
        left_hold <= '0;
      end else if (rise) begin
        if (is_switch) begin
          bit_cnt <= '0;
          if (state == SEARCH) begin
            // Only a right-to-left switch marks a frame boundary; the word
            // after it is the first left word.
            if (!lr_s2) begin
              state  <= RUN;
              locked <= 1'b1;
            end
          end else begin
            frame_err <= short_word;
            if (lr_s2) begin
              left_hold <= word;
            end else begin
              sample_left  <= left_hold;
              sample_right <= word;
              audio_out    <= mono_word;
              sample_valid <= 1'b1;
            end
          end
        end else if (bit_cnt != FULL_CNT) begin
          // Bits past DATA_W are slot padding and are ignored.
          shreg   <= {shreg[DATA_W-2:0], sdata_s2};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
//
// Bench for i2s_rx. Three instances (MONO_SEL = 0, 1, 2) share one I2S
// stream. A directed vector table drives known left/right pairs with
// hand-computed averages; hand-written sequences cover reset, BCLK stall /
// relock, random streaming and mid-frame reset. A negedge monitor pops an
// expected queue on every sample_valid.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

  localparam int W    = 24;
  localparam int HALF = 80;  // ns; BCLK period = 8 clk periods

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic i2s_bclk = 1'b0;
  logic i2s_lrclk = 1'b0;
  logic i2s_sdata = 1'b0;

  logic [W-1:0] sl0, sr0, ao0, sl1, sr1, ao1, sl2, sr2, ao2;
  logic sv0, sv1, sv2, lk0, lk1, lk2, fe0, fe1, fe2, st0, st1, st2;

  i2s_rx #(.DATA_W(W), .MONO_SEL(0), .TIMEOUT(1024)) dut0 (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .sample_left(sl0), .sample_right(sr0),
    .audio_out(ao0), .sample_valid(sv0), .locked(lk0), .frame_err(fe0),
    .fsm_state(st0)
  );
  i2s_rx #(.DATA_W(W), .MONO_SEL(1), .TIMEOUT(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .sample_left(sl1), .sample_right(sr1),
    .audio_out(ao1), .sample_valid(sv1), .locked(lk1), .frame_err(fe1),
    .fsm_state(st1)
  );
  i2s_rx #(.DATA_W(W), .MONO_SEL(2), .TIMEOUT(1024)) dut2 (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .sample_left(sl2), .sample_right(sr2),
    .audio_out(ao2), .sample_valid(sv2), .locked(lk2), .frame_err(fe2),
    .fsm_state(st2)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic         err;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] a2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_push = 0;
  int   n_valid = 0;
  logic prev_sv = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sv <= 1'b0;
    end else begin
      prev_sv <= sv0;
      if (sv0) begin
        exp_t e;
        n_valid++;
        chk("valid_width", W'(prev_sv), W'(0));
        chk("valid_align", W'({sv1, sv2}), W'(2'b11));
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", W'(1), W'(0));
        end else begin
          e = exp_q.pop_front();
          chk("left0", sl0, e.l);
          chk("right0", sr0, e.r);
          chk("mono_left", ao0, e.l);
          chk("mono_right", ao1, e.r);
          chk("mono_avg", ao2, e.a2);
          chk("left2", sl2, e.l);
          chk("right2", sr2, e.r);
          chk("frame_err", W'({fe0, fe2}), W'({e.err, e.err}));
        end
      end else if (sv1 || sv2 || fe0 || fe1 || fe2) begin
        chk("stray_strobe", W'({sv1, sv2, fe0, fe1, fe2}), W'(0));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Drive edges 7 ns after a clk rising edge; every later delay is a
  // multiple of the clk period so BCLK never lands on a clk edge.
  task automatic align();
    @(posedge clk);
    #7;
  endtask

  task automatic send_bit(input logic lr, input logic d);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = d;
    #(HALF);
    i2s_bclk  = 1'b1;
    #(HALF);
  endtask

  // One channel slot: delay bit, nbits data bits MSB-first, random padding.
  task automatic send_slot(input logic lr, input logic [W-1:0] word,
                           input int nbits, input int len);
    logic [W-1:0] w;
    w = word;
    send_bit(lr, 1'($urandom_range(0, 1)));
    for (int i = 0; i < len - 1; i++) begin
      if (i < nbits) send_bit(lr, w[W-1-i]);
      else           send_bit(lr, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input int rbits, input logic push,
                            input logic [W-1:0] exp_r, input logic [W-1:0] exp_a2,
                            input logic err);
    exp_t e;
    if (push) begin
      e.err = err;
      e.l   = l;
      e.r   = exp_r;
      e.a2  = exp_a2;
      exp_q.push_back(e);
      n_push++;
    end
    send_slot(1'b0, l, W, 32);
    send_slot(1'b1, r, rbits, (rbits == W) ? 32 : rbits + 1);
  endtask

  function automatic logic [W-1:0] avg_ref(input logic [W-1:0] l, input logic [W-1:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return W'(s >>> 1);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_left"}, sl0, '0);
    chk({tag, "_right"}, sr0, '0);
    chk({tag, "_audio0"}, ao0, '0);
    chk({tag, "_audio2"}, ao2, '0);
    chk({tag, "_valid"}, W'(sv0), '0);
    chk({tag, "_locked"}, W'({lk0, lk1, lk2}), '0);
    chk({tag, "_err"}, W'(fe0), '0);
    chk({tag, "_state"}, W'(st0), '0);
  endtask

  task automatic random_frame();
    logic [W-1:0] l, r;
    l = W'($urandom);
    r = W'($urandom);
    send_frame(l, r, W, 1'b1, r, avg_ref(l, r), 1'b0);
  endtask

  // -------------------------------------------------------------------------
  // Directed vectors
  // -------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           rbits;
    logic [W-1:0] exp_r;
    logic [W-1:0] exp_a2;
    logic         exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{24'h7FFFFF, 24'h800000, 24, 24'h800000, 24'hFFFFFF, 1'b0};
    vecs[1]  = '{24'h000003, 24'h000000, 24, 24'h000000, 24'h000001, 1'b0};
    vecs[2]  = '{24'hFFFFFF, 24'hFFFFFE, 24, 24'hFFFFFE, 24'hFFFFFE, 1'b0};
    vecs[3]  = '{24'h123456, 24'hABCD00, 16, 24'hABCD00, 24'hDF00AB, 1'b1};
    vecs[4]  = '{24'h000000, 24'h000000, 24, 24'h000000, 24'h000000, 1'b0};
    vecs[5]  = '{24'h800000, 24'h800000, 24, 24'h800000, 24'h800000, 1'b0};
    vecs[6]  = '{24'h000001, 24'hFFFFFF, 24, 24'hFFFFFF, 24'h000000, 1'b0};
    vecs[7]  = '{24'h400000, 24'h400001, 24, 24'h400001, 24'h400000, 1'b0};
    vecs[8]  = '{24'h7FFFFF, 24'h7FFFFF, 24, 24'h7FFFFF, 24'h7FFFFF, 1'b0};
    vecs[9]  = '{24'hA5A5A5, 24'h5A5A5A, 24, 24'h5A5A5A, 24'hFFFFFF, 1'b0};
    vecs[10] = '{24'h000002, 24'hFFFFFF, 24, 24'hFFFFFF, 24'h000000, 1'b0};
    vecs[11] = '{24'hFFFFFF, 24'h000000, 24, 24'h000000, 24'hFFFFFF, 1'b0};

    // Reset values
    repeat (5) @(negedge clk);
    check_zero("reset");
    align();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    align();

    // Sync frame: no 1->0 switch yet, so nothing is published from it.
    send_frame(24'h111111, 24'h222222, W, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      send_frame(vecs[i].l, vecs[i].r, vecs[i].rbits, 1'b1,
                 vecs[i].exp_r, vecs[i].exp_a2, vecs[i].exp_err);
    end
    // Left slot closes the last vector frame; right slot is cut short by a stall.
    send_slot(1'b0, 24'h0F0F0F, W, 32);
    send_slot(1'b1, 24'h999999, 10, 11);
    chk("locked_before_stall", W'(lk0), W'(1));
    chk("state_run", W'(st0), W'(1));

    // BCLK stall
    repeat (900) @(negedge clk);
    chk("locked_mid_stall", W'(lk0), W'(1));
    repeat (250) @(negedge clk);
    chk("locked_after_stall", W'({lk0, lk1, lk2}), W'(0));
    chk("state_search", W'(st0), W'(0));
    chk("hold_left", sl0, 24'hFFFFFF);
    chk("hold_right", sr0, 24'h000000);
    align();

    // Restart: last word select seen was right, so the first left slot is a
    // 1->0 switch and the first frame is already captured.
    random_frame();
    @(negedge clk);
    chk("relocked", W'(lk0), W'(1));
    align();
    for (int i = 0; i < 39; i++) random_frame();
    send_bit(1'b0, 1'b0);  // closing switch for the last random frame
    repeat (10) @(negedge clk);
    chk_int("queue_after_random", exp_q.size(), 0);
    align();

    // Mid-frame reset inside a left slot
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
    chk("locked_before_reset", W'(lk0), W'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    repeat (3) @(posedge clk);
    align();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    align();
    send_frame(24'h333333, 24'h444444, W, 1'b0, '0, '0, 1'b0);
    send_frame(24'h7FFFFF, 24'h800000, W, 1'b1, 24'h800000, 24'hFFFFFF, 1'b0);
    send_bit(1'b0, 1'b0);
    repeat (10) @(negedge clk);

    chk_int("valid_count", n_valid, n_push);
    chk_int("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation limit reached, bad=%0d", bad);
    $fatal(1, "time limit");
  end

endmodule
